// File: rtl/mux_stream_rr.sv
// Parametrised N-input registered valid/ready stream mux with fixed-select or round-robin arbitration.
// Optional packet lock (in_last/out_last) enabled by defining MUX_STREAM_LOCK_EN.
module mux_stream_rr #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
`ifdef MUX_STREAM_LOCK_EN
  input  logic [NUM_IN-1:0]         in_last,
  output logic                      out_last,
`endif
  input  logic                      mode_rr,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_src,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_src;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_ptr;

  logic              w_load;
  logic              w_xfer;
  logic              w_gnt_vld;
  logic [SEL_W-1:0]  w_gnt;
  logic              w_rr_vld;
  logic [SEL_W-1:0]  w_rr_gnt;
  logic [SEL_W-1:0]  w_rr_idx;
  logic [NUM_IN-1:0] w_in_ready;

`ifdef MUX_STREAM_LOCK_EN
  logic              r_lock;
  logic [SEL_W-1:0]  r_lock_ch;
  logic              r_out_last;
`endif

  assign w_load = !r_out_valid || out_ready;

  // Search starts one past the last RR grant so every channel gets a turn.
  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_gnt = '0;
    w_rr_idx = '0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      w_rr_idx = SEL_W'((32'(r_ptr) + k) % NUM_IN);
      if (!w_rr_vld && in_valid[w_rr_idx]) begin
        w_rr_vld = 1'b1;
        w_rr_gnt = w_rr_idx;
      end
    end
  end

  always_comb begin
    w_gnt     = sel;
    w_gnt_vld = 1'b0;
    if (mode_rr) begin
`ifdef MUX_STREAM_LOCK_EN
      if (r_lock) begin
        w_gnt     = r_lock_ch;
        w_gnt_vld = in_valid[r_lock_ch];
      end else begin
        w_gnt     = w_rr_gnt;
        w_gnt_vld = w_rr_vld;
      end
`else
      w_gnt     = w_rr_gnt;
      w_gnt_vld = w_rr_vld;
`endif
    end else if (32'(sel) < NUM_IN) begin
      w_gnt_vld = in_valid[sel];
    end
  end

  assign w_xfer = w_load && w_gnt_vld;

  always_comb begin
    w_in_ready = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      w_in_ready[i] = w_xfer && (w_gnt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= SEL_W'(NUM_IN - 1);
    end else begin
      if (w_load) begin
        r_out_valid <= w_gnt_vld;
      end
      if (w_xfer) begin
        r_out_data <= in_data[w_gnt*WIDTH +: WIDTH];
        r_out_src  <= w_gnt;
        if (mode_rr) begin
          r_ptr <= w_gnt;
        end
      end
    end
  end

`ifdef MUX_STREAM_LOCK_EN
  // Lock holds the grant on one channel until its last beat; fixed mode drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock     <= 1'b0;
      r_lock_ch  <= '0;
      r_out_last <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out_last <= in_last[w_gnt];
      end
      if (!mode_rr) begin
        r_lock <= 1'b0;
      end else if (w_xfer) begin
        r_lock    <= !in_last[w_gnt];
        r_lock_ch <= w_gnt;
      end
    end
  end

  assign out_last = r_out_last;
`endif

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;

endmodule
